// File: rtl/aes_word_packer.sv
// Packs 32-bit host words into 128-bit blocks, buffers them in a block FIFO and
// issues them to the AES encrypt core. Optional macro: AES_PACKER_BYTESWAP_EN.
module aes_word_packer #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       word_valid,
  input  logic [31:0]                word_in,
  output logic                       word_ready,
  input  logic                       flush,
  input  logic                       key_valid,
  output logic                       blk_ready,
  output logic [127:0]               blk_data,
  output logic [1:0]                 word_idx,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [127:0]  asm_q;
  logic [127:0]  blk_next;
  logic [31:0]   lane;
  logic [2:0]    cnt_post;
  logic          accept;
  logic          full_push;
  logic          fifo_full;
  logic          pop;
  logic          flush_go;
  logic          push;

`ifdef AES_PACKER_BYTESWAP_EN
  assign lane = {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
`else
  assign lane = word_in;
`endif

  assign fifo_full  = (fifo_count == DEPTH_C);
  assign word_ready = (word_idx != 2'd3) || !fifo_full;
  assign accept     = word_valid && word_ready;
  assign pop        = (fifo_count != '0) && key_valid;
  assign cnt_post   = {1'b0, word_idx} + {2'b00, accept};
  assign full_push  = accept && (word_idx == 2'd3);
  // cnt_post reaches 4 only through full_push, so nonzero here means 1..3
  assign flush_go   = flush && !full_push && (cnt_post != 3'd0) && (!fifo_full || pop);
  assign push       = full_push || flush_go;

  // asm_q is zeroed after every push, so lanes not yet written are already pad
  always_comb begin
    blk_next = asm_q;
    if (accept) begin
      case (word_idx)
        2'd0:    blk_next[127:96] = lane;
        2'd1:    blk_next[95:64]  = lane;
        2'd2:    blk_next[63:32]  = lane;
        default: blk_next[31:0]   = lane;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= blk_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      word_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      blk_ready  <= 1'b0;
      blk_data   <= '0;
    end else begin
      if (push) begin
        asm_q    <= '0;
        word_idx <= '0;
        wr_ptr   <= wr_ptr + AW'(1);
      end else if (accept) begin
        asm_q    <= blk_next;
        word_idx <= word_idx + 2'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        blk_data <= mem[rd_ptr];
      end
      blk_ready <= pop;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_packer.sv
// Directed self-checking bench for aes_word_packer (DEPTH=2).
module tb_aes_word_packer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         word_valid;
  logic [31:0]  word_in;
  logic         word_ready;
  logic         flush;
  logic         key_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [1:0]   word_idx;
  logic [1:0]   fifo_count;

  int checks = 0;
  int errors = 0;

  aes_word_packer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_in(word_in),
    .word_ready(word_ready), .flush(flush), .key_valid(key_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .word_idx(word_idx),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; word_valid = 1'b0; word_in = '0; flush = 1'b0; key_valid = 1'b0;
    #2;
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL rst_blk_ready: got %0b want 0", blk_ready); end
    checks++; if (blk_data !== 128'h0) begin errors++; $display("FAIL rst_blk_data: got %h want 0", blk_data); end
    checks++; if (word_idx !== 2'd0) begin errors++; $display("FAIL rst_word_idx: got %0d want 0", word_idx); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL rst_word_ready: got %0b want 1", word_ready); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    logic [31:0] w [4];
    w[0] = 32'h0; w[1] = 32'h0; w[2] = 32'h0; w[3] = 32'h69;
    key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1; word_in = w[i];
      step();
    end
    word_valid = 1'b0;
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL lat_e0_pulse: got %0b want 0", blk_ready); end
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL lat_e0_count: got %0d want 1", fifo_count); end
    step();
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL lat_e1_pulse: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'h69) begin errors++; $display("FAIL lat_e1_data: got %h want 69", blk_data); end
    step();
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL lat_e2_pulse: got %0b want 0", blk_ready); end
    checks++; if (blk_data !== 128'h69) begin errors++; $display("FAIL lat_e2_hold: got %h want 69", blk_data); end
  endtask

  task automatic test_flush();
    int pulses;
    key_valid = 1'b1;
    word_valid = 1'b1; word_in = 32'hAAAAAAAA; step();
    word_in = 32'hBBBBBBBB; step();
    word_valid = 1'b0;
    checks++; if (word_idx !== 2'd2) begin errors++; $display("FAIL fl_idx_before: got %0d want 2", word_idx); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (word_idx !== 2'd0) begin errors++; $display("FAIL fl_idx_after: got %0d want 0", word_idx); end
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL fl_count: got %0d want 1", fifo_count); end
    step();
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL fl_pulse: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'hAAAAAAAA_BBBBBBBB_00000000_00000000) begin errors++; $display("FAIL fl_data: got %h want aaaaaaaabbbbbbbb0000000000000000", blk_data); end
    step();
    flush = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (blk_ready) pulses++;
    end
    flush = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL fl_noop_pulses: got %0d want 0", pulses); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL fl_noop_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_push_pop();
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1; word_in = 32'h11 + i; step();
    end
    for (int i = 0; i < 3; i++) begin
      word_in = 32'h21 + i; step();
    end
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL pp_count_pre: got %0d want 1", fifo_count); end
    word_in = 32'h24; key_valid = 1'b1;
    step();
    word_valid = 1'b0;
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL pp_count_same: got %0d want 1", fifo_count); end
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL pp_pulse_a: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'h00000011_00000012_00000013_00000014) begin errors++; $display("FAIL pp_data_a: got %h", blk_data); end
    step();
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL pp_pulse_b: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'h00000021_00000022_00000023_00000024) begin errors++; $display("FAIL pp_data_b: got %h", blk_data); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL pp_count_end: got %0d want 0", fifo_count); end
    step();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    key_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 11; cyc++) begin
      word_valid = 1'b1; word_in = acc + 1;
      if (word_ready) acc++;
      step();
    end
    word_valid = 1'b1; word_in = 32'hC;
    checks++; if (acc !== 11) begin errors++; $display("FAIL bb_accepted: got %0d want 11", acc); end
    checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL bb_ready_low: got %0b want 0", word_ready); end
    checks++; if (word_idx !== 2'd3) begin errors++; $display("FAIL bb_idx: got %0d want 3", word_idx); end
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL bb_count: got %0d want 2", fifo_count); end
    step();
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL bb_stalled: got %0b want 0", blk_ready); end
    key_valid = 1'b1;
    step();
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL bb_pulse1: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'h00000001_00000002_00000003_00000004) begin errors++; $display("FAIL bb_data1: got %h", blk_data); end
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL bb_ready_back: got %0b want 1", word_ready); end
    step();
    word_valid = 1'b0;
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL bb_pulse2: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'h00000005_00000006_00000007_00000008) begin errors++; $display("FAIL bb_data2: got %h", blk_data); end
    checks++; if (word_idx !== 2'd0) begin errors++; $display("FAIL bb_idx_after: got %0d want 0", word_idx); end
    step();
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL bb_pulse3: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== 128'h00000009_0000000A_0000000B_0000000C) begin errors++; $display("FAIL bb_data3: got %h", blk_data); end
    step();
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL bb_pulse_end: got %0b want 0", blk_ready); end
  endtask

  task automatic test_byteswap();
    logic [127:0] exp;
`ifdef AES_PACKER_BYTESWAP_EN
    exp = 128'h01020304_01020304_01020304_01020304;
`else
    exp = 128'h04030201_04030201_04030201_04030201;
`endif
    key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1; word_in = 32'h04030201; step();
    end
    word_valid = 1'b0;
    step();
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL bs_pulse: got %0b want 1", blk_ready); end
    checks++; if (blk_data !== exp) begin errors++; $display("FAIL bs_data: got %h want %h", blk_data, exp); end
    step();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      word_valid = 1'b1; word_in = 32'h100 + i; step();
    end
    word_valid = 1'b0;
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL rm_count_pre: got %0d want 2", fifo_count); end
    checks++; if (word_idx !== 2'd2) begin errors++; $display("FAIL rm_idx_pre: got %0d want 2", word_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
    checks++; if (word_idx !== 2'd0) begin errors++; $display("FAIL rm_idx: got %0d want 0", word_idx); end
    checks++; if (blk_data !== 128'h0) begin errors++; $display("FAIL rm_data: got %h want 0", blk_data); end
    checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %0b want 1", word_ready); end
    key_valid = 1'b1;
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (blk_ready) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rm_pulses: got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flush();
    test_push_pop();
    test_back_to_back();
    test_byteswap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
